// File: rtl/load_scoreboard.sv
// -----------------------------------------------------------------------------
// load_scoreboard
//
// Issue-side scheduler for the VLIW bundle (ixu1, ixu2 and lsu lanes). It
// records the destination register of every outstanding variable-latency load
// and holds decode while any source or destination of the presented bundle is
// still waiting on load data. It also limits the number of loads in flight and
// runs a drain handshake used before fences and CSR writes. stall_out is OR'd
// with the existing load-use stall by the surrounding pipeline.
//
// Parameters:
//   MAX_OUTSTANDING  maximum loads in flight (1..15)
//   NUM_REGS         architectural register count (index width fixed at 5)
//
// Ports:
//   clk, rst_n              core clock, asynchronous active-low reset
//   issue_valid             decode presents a valid bundle
//   issue_ready             bundle advances this cycle (= !stall_out)
//   *_dc_rs1 / *_dc_rs2     bundle source registers (6 total)
//   *_dc_rd                 bundle destination registers (0 = none)
//   lsu_dc_is_load          lsu slot holds a load
//   mem_resp_valid/_rd      load data returning this cycle and its dest reg
//   drain_req               level request to drain all loads
//   drain_ack               one-cycle pulse when the drain completes
//   stall_out               hold decode
//   pending_mask            bit i set = load to register i outstanding
//   outstanding_cnt         loads in flight
//   err_resp                sticky: response for a non-pending register or
//                           response while no load is in flight
//
// Optional build macro:
//   LOAD_SCOREBOARD_RESP_BYPASS_EN  a response in cycle N already removes its
//   register (and one count) from that cycle's hazard check, letting a
//   dependent bundle issue one cycle earlier.
// -----------------------------------------------------------------------------
module load_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int NUM_REGS        = 32,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [4:0]          ixu1_dc_rs1,
    input  logic [4:0]          ixu1_dc_rs2,
    input  logic [4:0]          ixu2_dc_rs1,
    input  logic [4:0]          ixu2_dc_rs2,
    input  logic [4:0]          lsu_dc_rs1,
    input  logic [4:0]          lsu_dc_rs2,
    input  logic [4:0]          ixu1_dc_rd,
    input  logic [4:0]          ixu2_dc_rd,
    input  logic [4:0]          lsu_dc_rd,
    input  logic                lsu_dc_is_load,
    input  logic                mem_resp_valid,
    input  logic [4:0]          mem_resp_rd,
    input  logic                drain_req,
    output logic                drain_ack,
    output logic                stall_out,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [CNT_W-1:0]    outstanding_cnt,
    output logic                err_resp
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    state_t                state_q;
    state_t                state_next;

    logic [NUM_REGS-1:0]   pend_view;
    logic [CNT_W-1:0]      cnt_view;
    logic                  hazard;
    logic                  fire;
    logic                  cnt_inc;
    logic                  cnt_dec;
    logic [CNT_W-1:0]      cnt_next;
    logic [NUM_REGS-1:0]   set_vec;
    logic [NUM_REGS-1:0]   clr_vec;
    logic                  err_hit;

    // -------------------------------------------------------------------------
    // Hazard detection. The view of the scoreboard is the registered state,
    // optionally with this cycle's returning load already removed.
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block; a path that leaves one unassigned would infer a latch.
    always_comb begin
        pend_view = pending_mask;
        cnt_view  = outstanding_cnt;
`ifdef LOAD_SCOREBOARD_RESP_BYPASS_EN
        if (mem_resp_valid) begin
            pend_view[mem_resp_rd] = 1'b0;
            if (outstanding_cnt != '0) begin
                cnt_view = outstanding_cnt - 1'b1;
            end
        end
`endif
        // x0 is never a real dependency; forcing it clear here also makes the
        // "nonzero destination" qualifier of the WAW check implicit.
        pend_view[0] = 1'b0;

        hazard = pend_view[ixu1_dc_rs1] | pend_view[ixu1_dc_rs2] |
                 pend_view[ixu2_dc_rs1] | pend_view[ixu2_dc_rs2] |
                 pend_view[lsu_dc_rs1]  | pend_view[lsu_dc_rs2]  |
                 pend_view[ixu1_dc_rd]  | pend_view[ixu2_dc_rd]  |
                 pend_view[lsu_dc_rd]   |
                 (lsu_dc_is_load && (cnt_view == MAX_CNT));
    end

    // -------------------------------------------------------------------------
    // Drain FSM and issue control.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_q;
        drain_ack  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (drain_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outstanding_cnt == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                drain_ack  = 1'b1;
                state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase

        stall_out   = issue_valid && (hazard || (state_q != ST_RUN));
        issue_ready = !stall_out;
        fire        = issue_valid && !stall_out;
    end

    // -------------------------------------------------------------------------
    // Scoreboard next-state. Set and clear act on their own bits; a new load
    // takes precedence over a response to the same register (only reachable
    // with the bypass build, where the WAW check is masked for that register).
    // -------------------------------------------------------------------------
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        cnt_inc = fire && lsu_dc_is_load;
        cnt_dec = mem_resp_valid && (outstanding_cnt != '0);

        if (cnt_inc && (lsu_dc_rd != 5'd0)) begin
            set_vec[lsu_dc_rd] = 1'b1;
        end
        if (mem_resp_valid) begin
            clr_vec[mem_resp_rd] = 1'b1;
        end

        unique case ({cnt_inc, cnt_dec})
            2'b10:   cnt_next = outstanding_cnt + 1'b1;
            2'b01:   cnt_next = outstanding_cnt - 1'b1;
            default: cnt_next = outstanding_cnt;
        endcase

        err_hit = mem_resp_valid &&
                  ((outstanding_cnt == '0) ||
                   ((mem_resp_rd != 5'd0) && !pending_mask[mem_resp_rd]));
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge values of the others. pending_mask is a
    // bank of flops rather than a RAM, so it takes the async reset like the
    // rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            pending_mask    <= '0;
            outstanding_cnt <= '0;
            err_resp        <= 1'b0;
        end else begin
            state_q         <= state_next;
            pending_mask    <= (pending_mask & ~clr_vec) | set_vec;
            outstanding_cnt <= cnt_next;
            err_resp        <= err_resp | err_hit;
        end
    end

endmodule

// File: tb/tb_load_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_load_scoreboard
//
// Directed scenarios followed by a randomized phase. Expected values come from
// a behavioural model of the scoreboard (an array of pending flags, an integer
// load count and a drain phase) evaluated from the bundle rules.
// -----------------------------------------------------------------------------
module tb_load_scoreboard;

    localparam int MAX  = 4;
    localparam int NREG = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  ixu1_dc_rs1, ixu1_dc_rs2, ixu2_dc_rs1, ixu2_dc_rs2;
    logic [4:0]  lsu_dc_rs1, lsu_dc_rs2;
    logic [4:0]  ixu1_dc_rd, ixu2_dc_rd, lsu_dc_rd;
    logic        lsu_dc_is_load;
    logic        mem_resp_valid;
    logic [4:0]  mem_resp_rd;
    logic        drain_req;
    logic        drain_ack;
    logic        stall_out;
    logic [NREG-1:0] pending_mask;
    logic [2:0]  outstanding_cnt;
    logic        err_resp;

    load_scoreboard #(.MAX_OUTSTANDING(MAX), .NUM_REGS(NREG)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .ixu1_dc_rs1     (ixu1_dc_rs1),
        .ixu1_dc_rs2     (ixu1_dc_rs2),
        .ixu2_dc_rs1     (ixu2_dc_rs1),
        .ixu2_dc_rs2     (ixu2_dc_rs2),
        .lsu_dc_rs1      (lsu_dc_rs1),
        .lsu_dc_rs2      (lsu_dc_rs2),
        .ixu1_dc_rd      (ixu1_dc_rd),
        .ixu2_dc_rd      (ixu2_dc_rd),
        .lsu_dc_rd       (lsu_dc_rd),
        .lsu_dc_is_load  (lsu_dc_is_load),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_rd     (mem_resp_rd),
        .drain_req       (drain_req),
        .drain_ack       (drain_ack),
        .stall_out       (stall_out),
        .pending_mask    (pending_mask),
        .outstanding_cnt (outstanding_cnt),
        .err_resp        (err_resp)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    typedef enum int {M_RUN, M_DRAIN, M_DONE} mode_t;

    bit    m_pend [NREG];
    int    m_cnt;
    bit    m_err;
    mode_t m_mode;
    int    x0_out;      // loads to x0 still in flight (stimulus bookkeeping)

    int    n_compared   = 0;
    int    n_mismatched = 0;
    bit    last_stall;
    bit    last_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_cnt  = 0;
        m_err  = 1'b0;
        m_mode = M_RUN;
        x0_out = 0;
    endtask

    function automatic logic [31:0] exp_mask();
        logic [31:0] m = '0;
        for (int i = 0; i < NREG; i++) m[i] = m_pend[i];
        return m;
    endfunction

    function automatic bit model_stall();
        bit        p [NREG];
        int        c;
        logic [4:0] regs [9];
        if (!issue_valid) return 1'b0;
        if (m_mode != M_RUN) return 1'b1;
        p = m_pend;
        c = m_cnt;
`ifdef LOAD_SCOREBOARD_RESP_BYPASS_EN
        if (mem_resp_valid) begin
            p[mem_resp_rd] = 1'b0;
            if (c > 0) c--;
        end
`endif
        regs = '{ixu1_dc_rs1, ixu1_dc_rs2, ixu2_dc_rs1, ixu2_dc_rs2,
                 lsu_dc_rs1, lsu_dc_rs2, ixu1_dc_rd, ixu2_dc_rd, lsu_dc_rd};
        foreach (regs[k]) if (regs[k] != 5'd0 && p[regs[k]]) return 1'b1;
        if (lsu_dc_is_load && c == MAX) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input bit stall);
        bit fire   = issue_valid && !stall;
        int cnt_in = m_cnt;
        case (m_mode)
            M_RUN:   if (drain_req) m_mode = M_DRAIN;
            M_DRAIN: if (cnt_in == 0) m_mode = M_DONE;
            default: m_mode = M_RUN;
        endcase
        if (mem_resp_valid) begin
            if (cnt_in == 0 || (mem_resp_rd != 5'd0 && !m_pend[mem_resp_rd])) m_err = 1'b1;
            if (mem_resp_rd != 5'd0) m_pend[mem_resp_rd] = 1'b0;
            else if (x0_out > 0) x0_out--;
            if (m_cnt > 0) m_cnt--;
        end
        if (fire && lsu_dc_is_load) begin
            m_cnt++;
            if (lsu_dc_rd != 5'd0) m_pend[lsu_dc_rd] = 1'b1;
            else x0_out++;
        end
    endtask

    // ------------------------------------------------------------ stimulus
    task automatic set_bundle(input bit v, input int r1a, input int r1b, input int r2a,
                              input int r2b, input int rla, input int rlb, input int d1,
                              input int d2, input int dl, input bit ld);
        issue_valid    = v;
        ixu1_dc_rs1    = 5'(r1a);
        ixu1_dc_rs2    = 5'(r1b);
        ixu2_dc_rs1    = 5'(r2a);
        ixu2_dc_rs2    = 5'(r2b);
        lsu_dc_rs1     = 5'(rla);
        lsu_dc_rs2     = 5'(rlb);
        ixu1_dc_rd     = 5'(d1);
        ixu2_dc_rd     = 5'(d2);
        lsu_dc_rd      = 5'(dl);
        lsu_dc_is_load = ld;
    endtask

    task automatic set_resp(input bit v, input int rd);
        mem_resp_valid = v;
        mem_resp_rd    = 5'(rd);
    endtask

    task automatic idle();
        set_bundle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_resp(0, 0);
        drain_req = 1'b0;
    endtask

    task automatic load_to(input int rd);
        set_bundle(1, 0, 0, 0, 0, 0, 0, 0, 0, rd, 1);
    endtask

    // Called at a falling edge with inputs already driven; compares, then
    // advances the model and the DUT by one rising edge.
    task automatic step(input string tag);
        bit st;
        #1;
        st = model_stall();
        last_stall = stall_out;
        last_ack   = drain_ack;
        check({tag, ".stall"},   32'(stall_out),       32'(st));
        check({tag, ".ready"},   32'(issue_ready),     32'(!st));
        check({tag, ".ack"},     32'(drain_ack),       32'(m_mode == M_DONE));
        check({tag, ".mask"},    pending_mask,         exp_mask());
        check({tag, ".cnt"},     32'(outstanding_cnt), 32'(m_cnt));
        check({tag, ".err"},     32'(err_resp),        32'(m_err));
        model_edge(st);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #2;
        check({tag, ".rst_mask"},  pending_mask,          32'h0);
        check({tag, ".rst_cnt"},   32'(outstanding_cnt),  32'h0);
        check({tag, ".rst_err"},   32'(err_resp),         32'h0);
        check({tag, ".rst_ack"},   32'(drain_ack),        32'h0);
        check({tag, ".rst_stall"}, 32'(stall_out),        32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int stalls;
        int ack_at;
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        apply_reset("init");

        // --- Dependent bundle waits for a load (RAW), response at +3.
        load_to(5);
        step("t1.load");
        stalls = 0;
        k = 1;
        for (int c = 1; c <= 8; c++) begin
            set_bundle(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            set_resp(c == 3, 5);
            step("t1.dep");
            k = c;
            if (!last_stall) break;
            stalls++;
        end
`ifdef LOAD_SCOREBOARD_RESP_BYPASS_EN
        check("t1.issue_cycle", 32'(k), 32'd3);
`else
        check("t1.issue_cycle", 32'(k), 32'd4);
`endif
        idle();
        step("t1.idle");
        check("t1.x5_clear", 32'(pending_mask[5]), 32'h0);

        // --- Outstanding cap: 4 loads, 5th stalls until one returns.
        apply_reset("t2");
        for (int r = 1; r <= 4; r++) begin
            load_to(r);
            step("t2.fill");
        end
        #1;
        check("t2.cnt_full", 32'(outstanding_cnt), 32'd4);
        load_to(6);
        step("t2.fifth");
        check("t2.fifth_stalled", 32'(last_stall), 32'd1);
        set_resp(1, 2);
        step("t2.resp");
        set_resp(0, 0);
        for (int c = 0; c < 3 && m_pend[6] == 1'b0; c++) step("t2.issue");
        idle();
        step("t2.end");
        check("t2.cnt_back", 32'(outstanding_cnt), 32'd4);

        // --- WAW on ixu2_rd, then x0 load never stalls readers of x0.
        apply_reset("t3");
        load_to(7);
        step("t3.load");
        for (int c = 1; c <= 5; c++) begin
            set_bundle(1, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
            set_resp(c == 3, 7);
            step("t3.waw");
            if (!last_stall) break;
        end
        idle();
        load_to(0);
        step("t3.x0_load");
        set_bundle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("t3.x0_nostall", 32'(stall_out), 32'h0);
        check("t3.x0_cnt",     32'(outstanding_cnt), 32'd1);
        idle();
        set_resp(1, 0);
        step("t3.x0_resp");
        idle();
        step("t3.end");

        // --- Drain with two loads, responses at +2 and +5, ack at +7.
        apply_reset("t4");
        load_to(10);
        step("t4.ld0");
        load_to(11);
        step("t4.ld1");
        ack_at = -1;
        for (int c = 0; c <= 9; c++) begin
            set_bundle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            drain_req = (c == 0);
            set_resp(c == 2 || c == 5, (c == 2) ? 10 : 11);
            step("t4.drain");
            if (last_ack) begin
                if (ack_at < 0) ack_at = c;
                else check("t4.ack_once", 32'(c), 32'(ack_at));
            end
            if (c == 8) check("t4.run_again", 32'(last_stall), 32'h0);
        end
        check("t4.ack_cycle", 32'(ack_at), 32'd7);

        // --- Randomized traffic.
        apply_reset("rnd");
        for (int c = 0; c < 400; c++) begin
            int cands[$];
            set_bundle($urandom_range(0, 3) != 0,
                       $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 1));
            cands.delete();
            for (int r = 1; r < 8; r++) if (m_pend[r]) cands.push_back(r);
            if (x0_out > 0) cands.push_back(0);
            if (cands.size() > 0 && $urandom_range(0, 2) != 0)
                set_resp(1, cands[$urandom_range(0, cands.size() - 1)]);
            else
                set_resp(0, 0);
            drain_req = (m_mode == M_RUN) && ($urandom_range(0, 30) == 0);
            step("rnd");
        end

        // --- Response with nothing in flight: sticky error, count stays 0.
        apply_reset("t5");
        set_resp(1, 9);
        step("t5.bad_resp");
        idle();
        step("t5.after");
        step("t5.sticky");
        #1;
        check("t5.err_set", 32'(err_resp), 32'd1);
        check("t5.cnt_zero", 32'(outstanding_cnt), 32'd0);
        apply_reset("t5.clear");

        // --- Reset in the middle of a drain with three loads pending.
        for (int r = 1; r <= 3; r++) begin
            load_to(r);
            step("t6.fill");
        end
        idle();
        drain_req = 1'b1;
        step("t6.req");
        drain_req = 1'b0;
        step("t6.draining");
        set_bundle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.mask",  pending_mask,         32'h0);
        check("t6.cnt",   32'(outstanding_cnt), 32'h0);
        check("t6.stall", 32'(stall_out),       32'h0);
        check("t6.ack",   32'(drain_ack),       32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        for (int c = 0; c < 4; c++) begin
            step("t6.post");
            check("t6.no_ack", 32'(last_ack), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/load_scoreboard.md
Name: load_scoreboard

Overview:
- Issue-side scheduler for the VLIW bundle (ixu1, ixu2, lsu lanes). It tracks destination registers of outstanding variable-latency loads and holds decode until every source and destination of the bundle is free.
- Also caps the number of loads in flight and provides a drain sequence used before fences and CSR writes.
- Sits between decode and execute. Its stall is OR'd with the existing load-use stall.

Parameters:
- MAX_OUTSTANDING, 4: maximum loads in flight; legal range 1-15.
- NUM_REGS, 32: architectural register count; register index width fixed at 5.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode holds a valid bundle
- issue_ready  out  1  bundle may advance this cycle (= !stall_out)
- ixu1_dc_rs1, ixu1_dc_rs2, ixu2_dc_rs1, ixu2_dc_rs2, lsu_dc_rs1, lsu_dc_rs2  in  5 each  bundle source regs
- ixu1_dc_rd, ixu2_dc_rd, lsu_dc_rd  in  5 each  bundle dest regs (0 = none)
- lsu_dc_is_load  in  1  lsu slot holds a load
- mem_resp_valid  in  1  load data returning this cycle
- mem_resp_rd  in  5  dest reg of returning load
- drain_req  in  1  level; request drain of all loads
- drain_ack  out  1  one-cycle pulse when drain completes
- stall_out  out  1  hold decode
- pending_mask  out  NUM_REGS  bit i set = load to reg i outstanding
- outstanding_cnt  out  clog2(MAX_OUTSTANDING+1)  loads in flight
- err_resp  out  1  sticky: response for a non-pending reg, or response with count 0

Behaviour:
- Reset values (async, on rst_n low): pending_mask 0, outstanding_cnt 0, FSM RUN, drain_ack 0, err_resp 0. stall_out is 0 after reset because it is derived from the reset state.
- Register 0 is never set pending and never causes a stall.
- Hazard (combinational, from registered state):
  - any of the 6 sources is pending;
  - or any nonzero dest is pending (WAW);
  - or lsu_dc_is_load && outstanding_cnt == MAX_OUTSTANDING.
- stall_out = issue_valid && (hazard || state != RUN).
- Fire = issue_valid && !stall_out. On fire with lsu_dc_is_load && lsu_dc_rd != 0: set pending[lsu_dc_rd] and increment the count next edge.
  - A load to x0 still increments and decrements the count; responses to x0 are legal whenever count > 0.
- On mem_resp_valid:
  - clear pending[mem_resp_rd] and decrement the count.
  - If count == 0: no decrement, set err_resp.
  - If rd != 0 and not pending: set err_resp, the count still decrements.
- Same cycle issue + response: net count unchanged; set and clear apply to their own bits. Same-reg set+clear cannot occur, because the WAW stall blocks it.
- No bypass: a response in cycle N clears the hazard from cycle N+1.
- FSM:
  - RUN -> DRAIN when drain_req=1 (checked every cycle, including while stalled).
  - DRAIN: stall_out = issue_valid; waits for outstanding_cnt == 0 (registered), then -> DONE.
  - DONE: drain_ack = 1 for exactly one cycle, stall held; -> RUN unconditionally.
  - drain_req must drop before the next drain. If still high in RUN, a new drain starts.
  - Drain with count already 0 takes 2 cycles: DRAIN, then DONE.
- Count never wraps. It saturates at MAX_OUTSTANDING, which the full-stall guarantees.
- err_resp clears only on reset.
- Reset mid-drain returns to RUN with all state cleared. No drain_ack is produced.

Optional Feature:
- Macro: LOAD_SCOREBOARD_RESP_BYPASS_EN.
- Defined: a response with mem_resp_valid in cycle N masks pending[mem_resp_rd] out of the hazard check in cycle N. The full check uses count-1 for that cycle. A dependent bundle issues in the same cycle, saving one stall cycle.
- Undefined: behaviour as above; hazard uses registered state only.

Test Plan:
- Load x5, then a bundle with ixu1_rs1=5; response at cycle +3 -> stall_out=1 for cycles 1-3, issue in cycle 4 (cycle 3 with bypass macro); pending_mask[5] clears at +4.
- 4 loads to x1..x4 with no response, then a 5th load -> stall_out=1. One response on x2 -> 5th load issues next cycle; outstanding_cnt goes 4->3->4.
- Bundle with ixu2_rd=7 while x7 pending -> stall until x7 returns. Bundle with rs1=0 and x0 load outstanding -> no stall.
- drain_req with 2 loads in flight, responses at +2 and +5 -> DRAIN until count=0, drain_ack pulse exactly one cycle at +7, RUN at +8.
- mem_resp_valid with rd=9 not pending and count=0 -> err_resp=1 sticky, count stays 0. Then rst_n low -> err_resp=0.
- Assert rst_n low mid-DRAIN with 3 pending -> immediate pending_mask=0, count=0, stall_out=0, no drain_ack.
